// File: rtl/face_pkg.sv
`default_nettype none
// ============================================================================
// Package : face_pkg
// Purpose : Shared constants, state and command-class types for the FACE
//           command scheduler, plus the opcode/func classifier.
// Contents: SYSOPCODE, ADDRSET_FUNC, CALC_FUNC, NOP_INSTR, state_e,
//           cmd_class_e, classify()
// Revision: 1.0 - initial release
// ============================================================================
package face_pkg;

  localparam logic [6:0]  SYSOPCODE    = 7'b0001011;
  localparam logic [2:0]  ADDRSET_FUNC = 3'd0;
  localparam logic [2:0]  CALC_FUNC    = 3'd1;
  localparam logic [31:0] NOP_INSTR    = 32'd0;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_WAIT_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CLS_ADDRSET = 2'd0,
    CLS_CALC    = 2'd1,
    CLS_ILLEGAL = 2'd2
  } cmd_class_e;

  // Only the opcode and func fields decide the class; everything else in
  // the word is payload for the accelerator.
  function automatic cmd_class_e classify(input logic [6:0] opcode,
                                          input logic [2:0] func);
    cmd_class_e cls;
    cls = CLS_ILLEGAL;
    if (opcode == SYSOPCODE) begin
      if (func == ADDRSET_FUNC) begin
        cls = CLS_ADDRSET;
      end else if (func == CALC_FUNC) begin
        cls = CLS_CALC;
      end
    end
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/face_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : face_cmd_fifo
// Purpose : Command FIFO for the FACE scheduler. Show-ahead read (head word
//           is always visible on rdata_o), synchronous flush.
// Ports   : clk, rst_n   - clock, async active-low reset
//           push_i       - write request (ignored while full)
//           pop_i        - remove head entry (caller pops only when non-empty)
//           flush_i      - empty the FIFO on the next edge, overrides push
//           wdata_i      - word to write
//           rdata_o      - head word
//           full_o, empty_o, count_o - occupancy status
// Revision: 1.0 - initial release
// ============================================================================
module face_cmd_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [31:0]              wdata_i,
  output logic [31:0]              rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push is refused when full, even if a pop frees a slot this cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are AW bits wide on a power-of-two depth, so they wrap
  // naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage has no reset; occupancy alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/face_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module  : face_cmd_sched
// Purpose : Queues host commands and issues them to the FACE accelerator one
//           per cycle, holding further issue while a calc is in flight.
// Ports   : clk, rst_n        - clock, async active-low reset
//           cmd_valid/instr   - host command push, cmd_ready = FIFO not full
//           flush             - discard all queued commands
//           instr_out         - registered instruction, NOP except issue cycle
//           face_busy         - accelerator busy
//           calc_done         - one-cycle pulse at calc completion
//           err_illegal       - one-cycle pulse when an unknown command drops
//           err_timeout       - sticky, busy never rose after a calc issue
//           q_count, idle     - occupancy and idle status
// Revision: 1.0 - initial release
// ============================================================================
module face_cmd_sched
  import face_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int START_TMO = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  input  logic [31:0]            cmd_instr,
  output logic                   cmd_ready,
  input  logic                   flush,
  output logic [31:0]            instr_out,
  input  logic                   face_busy,
  output logic                   calc_done,
  output logic                   err_illegal,
  output logic                   err_timeout,
  output logic [$clog2(DEPTH):0] q_count,
  output logic                   idle
);

  localparam int TW = (START_TMO > 1) ? $clog2(START_TMO) : 1;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q;
  logic [31:0]   instr_out_q;
  logic          calc_done_q;
  logic          err_illegal_q;
  logic          err_timeout_q;

  logic          fifo_full;
  logic          fifo_empty;
  logic [31:0]   head_instr;
  cmd_class_e    head_cls;
  logic          tmo_last;

  logic          pop;
  logic          issue;
  logic          illegal;
  logic          done;
  logic          tmo_hit;

  face_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_valid),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (cmd_instr),
    .rdata_o (head_instr),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (q_count)
  );

  assign head_cls = classify(head_instr[6:0], head_instr[9:7]);
  // tmo_q counts S_WAIT_START cycles from 0; the last allowed one is
  // START_TMO-1.
  assign tmo_last = (tmo_q == TW'(START_TMO - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && head_cls == CLS_CALC && !face_busy) begin
          state_d = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (face_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_last) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_DONE: begin
        if (!face_busy) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode. Pops only happen in S_IDLE, so nothing leaves the queue
  // while a calc is in flight. A CALC at the head while busy is held.
  always_comb begin
    pop     = 1'b0;
    issue   = 1'b0;
    illegal = 1'b0;
    done    = 1'b0;
    tmo_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          case (head_cls)
            CLS_ADDRSET: begin
              pop   = 1'b1;
              issue = 1'b1;
            end
            CLS_CALC: begin
              if (!face_busy) begin
                pop   = 1'b1;
                issue = 1'b1;
              end
            end
            default: begin
              pop     = 1'b1;
              illegal = 1'b1;
            end
          endcase
        end
      end
      S_WAIT_START: begin
        tmo_hit = !face_busy && tmo_last;
      end
      S_WAIT_DONE: begin
        done = !face_busy;
      end
      default: ;
    endcase
  end

  // Registered outputs and the start-timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_out_q   <= NOP_INSTR;
      calc_done_q   <= 1'b0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
      tmo_q         <= '0;
    end else begin
      instr_out_q   <= issue ? head_instr : NOP_INSTR;
      calc_done_q   <= done;
      err_illegal_q <= illegal;
      err_timeout_q <= err_timeout_q | tmo_hit;
      if (state_q == S_WAIT_START) begin
        tmo_q <= tmo_q + 1'b1;
      end else begin
        tmo_q <= '0;
      end
    end
  end

  assign instr_out   = instr_out_q;
  assign calc_done   = calc_done_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;
  assign cmd_ready   = !fifo_full;
  assign idle        = fifo_empty && (state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_face_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_face_cmd_sched
// Purpose : Self-checking bench for face_cmd_sched. A queue-level model
//           predicts every output each cycle; directed scenarios add literal
//           expectations at key points.
// Revision: 1.0 - initial release
// ============================================================================
module tb_face_cmd_sched;

  localparam int DEPTH     = 8;
  localparam int START_TMO = 4;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_instr = 32'd0;
  logic        flush     = 1'b0;
  logic        face_busy = 1'b0;

  logic        cmd_ready;
  logic [31:0] instr_out;
  logic        calc_done;
  logic        err_illegal;
  logic        err_timeout;
  logic [3:0]  q_count;
  logic        idle;

  int errors = 0;
  int checks = 0;

  face_cmd_sched #(
    .DEPTH     (DEPTH),
    .START_TMO (START_TMO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_instr   (cmd_instr),
    .cmd_ready   (cmd_ready),
    .flush       (flush),
    .instr_out   (instr_out),
    .face_busy   (face_busy),
    .calc_done   (calc_done),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout),
    .q_count     (q_count),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  // Command word: arg in [22:12], func in [9:7], system opcode in [6:0]
  function automatic logic [31:0] mk(input logic [2:0] func, input logic [10:0] arg);
    return {9'd0, arg, 2'b00, func, 7'b0001011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mq is the command queue; m_state 0=idle, 1=waiting for busy, 2=calc running
  logic [31:0] mq[$];
  int          m_state = 0;
  int          m_wait  = 0;
  logic [31:0] e_instr = 32'd0;
  logic        e_done  = 1'b0;
  logic        e_ill   = 1'b0;
  logic        e_tmo   = 1'b0;
  logic        m_full;
  logic [31:0] m_head;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_state = 0;
      m_wait  = 0;
      e_instr = 32'd0;
      e_done  = 1'b0;
      e_ill   = 1'b0;
      e_tmo   = 1'b0;
    end else begin
      m_full  = (mq.size() == DEPTH);
      e_instr = 32'd0;
      e_done  = 1'b0;
      e_ill   = 1'b0;
      if (m_state == 0) begin
        if (mq.size() > 0) begin
          m_head = mq[0];
          if (m_head[6:0] == 7'h0B && m_head[9:7] == 3'd0) begin
            e_instr = mq.pop_front();
          end else if (m_head[6:0] == 7'h0B && m_head[9:7] == 3'd1) begin
            if (!face_busy) begin
              e_instr = mq.pop_front();
              m_state = 1;
              m_wait  = 0;
            end
          end else begin
            void'(mq.pop_front());
            e_ill = 1'b1;
          end
        end
      end else if (m_state == 1) begin
        if (face_busy) begin
          m_state = 2;
        end else begin
          m_wait++;
          if (m_wait == START_TMO) begin
            e_tmo   = 1'b1;
            m_state = 0;
          end
        end
      end else begin
        if (!face_busy) begin
          e_done  = 1'b1;
          m_state = 0;
        end
      end
      if (cmd_valid && !m_full) mq.push_back(cmd_instr);
      if (flush) mq.delete();
    end
  end

  // ---------------- per-cycle compare ----------------
  logic run_cmp = 1'b1;
  always @(negedge clk) begin
    if (run_cmp) begin
      chk("instr_out",   instr_out,   e_instr);
      chk("calc_done",   {31'd0, calc_done},   {31'd0, e_done});
      chk("err_illegal", {31'd0, err_illegal}, {31'd0, e_ill});
      chk("err_timeout", {31'd0, err_timeout}, {31'd0, e_tmo});
      chk("q_count",     {28'd0, q_count},     32'(mq.size()));
      chk("cmd_ready",   {31'd0, cmd_ready},   {31'd0, (mq.size() < DEPTH)});
      chk("idle",        {31'd0, idle},        {31'd0, (mq.size() == 0 && m_state == 0)});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    cmd_valid = 1'b1;
    cmd_instr = w;
    tick();
    cmd_valid = 1'b0;
  endtask

  logic [31:0] a_w [4];
  logic [31:0] calc_w;
  logic [31:0] ill_w;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4; i++) a_w[i] = mk(3'd0, 11'(16 + i));
    calc_w = mk(3'd1, 11'd640);
    ill_w  = 32'h0000_0033;

    // Reset state
    repeat (3) tick();
    chk("rst_q_count",   {28'd0, q_count}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_idle",      {31'd0, idle}, 32'd1);
    chk("rst_instr_out", instr_out, 32'd0);
    rst_n = 1'b1;
    tick();

    // Back-to-back ADDRSET stream issues on consecutive cycles
    push(mk(3'd0, 11'd1));
    push(mk(3'd0, 11'd2));
    chk("stream_0", instr_out, 32'h0000_100B);
    push(mk(3'd0, 11'd3));
    chk("stream_1", instr_out, 32'h0000_200B);
    tick();
    chk("stream_2", instr_out, 32'h0000_300B);
    tick();
    chk("stream_end", instr_out, 32'd0);
    chk("stream_idle", {31'd0, idle}, 32'd1);

    // CALC with 4 ADDRSETs queued behind it during the calc
    push(calc_w);
    tick();
    chk("calc_issue", instr_out, 32'h0028_008B);
    tick();
    face_busy = 1'b1;
    for (int i = 0; i < 4; i++) push(a_w[i]);
    repeat (16) tick();
    chk("calc_q4", {28'd0, q_count}, 32'd4);
    chk("calc_no_issue", instr_out, 32'd0);
    face_busy = 1'b0;
    for (int i = 0; i < 4 && !calc_done; i++) tick();
    chk("calc_done_seen", {31'd0, calc_done}, 32'd1);
    chk("calc_done_q4", {28'd0, q_count}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("drain_instr", instr_out, 32'h0001_000B + 32'(i) * 32'h1000);
      chk("drain_count", {28'd0, q_count}, 32'(3 - i));
    end
    tick();
    chk("drain_end", instr_out, 32'd0);

    // CALC held while accelerator busy
    face_busy = 1'b1;
    push(calc_w);
    repeat (4) tick();
    chk("hold_instr", instr_out, 32'd0);
    chk("hold_count", {28'd0, q_count}, 32'd1);
    face_busy = 1'b0;
    tick();
    chk("hold_issue", instr_out, calc_w);
    tick();
    face_busy = 1'b1;
    repeat (3) tick();
    face_busy = 1'b0;
    for (int i = 0; i < 4 && !calc_done; i++) tick();
    chk("hold_done_seen", {31'd0, calc_done}, 32'd1);
    tick();

    // Start timeout
    push(calc_w);
    tick();
    chk("tmo_issue", instr_out, calc_w);
    repeat (3) tick();
    chk("tmo_not_yet", {31'd0, err_timeout}, 32'd0);
    tick();
    chk("tmo_set", {31'd0, err_timeout}, 32'd1);
    chk("tmo_idle", {31'd0, idle}, 32'd1);
    chk("tmo_no_done", {31'd0, calc_done}, 32'd0);

    // Fill to full, refused pushes, flush
    face_busy = 1'b1;
    push(calc_w);
    for (int i = 1; i < DEPTH; i++) push(mk(3'd0, 11'(100 + i)));
    chk("full_count", {28'd0, q_count}, 32'd8);
    chk("full_ready", {31'd0, cmd_ready}, 32'd0);
    push(mk(3'd0, 11'd200));
    chk("full_ninth", {28'd0, q_count}, 32'd8);
    face_busy = 1'b0;
    push(mk(3'd0, 11'd201));
    chk("full_pop_push", {28'd0, q_count}, 32'd7);
    chk("full_pop_issue", instr_out, calc_w);
    flush = 1'b1;
    push(mk(3'd0, 11'd202));
    flush = 1'b0;
    chk("flush_count", {28'd0, q_count}, 32'd0);
    repeat (4) tick();
    chk("flush_idle", {31'd0, idle}, 32'd1);

    // Illegal opcode
    push(ill_w);
    tick();
    chk("ill_pulse", {31'd0, err_illegal}, 32'd1);
    chk("ill_instr", instr_out, 32'd0);
    tick();
    chk("ill_clear", {31'd0, err_illegal}, 32'd0);

    // Reset during a running calc
    push(calc_w);
    tick();
    tick();
    face_busy = 1'b1;
    repeat (2) tick();
    chk("pre_rst_tmo", {31'd0, err_timeout}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_instr", instr_out, 32'd0);
    chk("mid_rst_tmo", {31'd0, err_timeout}, 32'd0);
    chk("mid_rst_idle", {31'd0, idle}, 32'd1);
    chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    face_busy = 1'b0;
    repeat (3) begin
      tick();
      chk("post_rst_no_done", {31'd0, calc_done}, 32'd0);
    end

    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
